// File: rtl/wb_coherent_pkg.sv
// Shared types and constants for the coherent Wishbone memory arbiter.
// No logic; state encoding, CTI codes and bus widths.
// Backpressure: n/a.
package wb_coherent_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SNOOP = 2'd1,
    WAIT  = 2'd2,
    GRANT = 2'd3
  } state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;

endpackage

// File: rtl/wb_snoop_arbiter_rr_arbiter.sv
// Round-robin pick: first set request after the last owner, wrapping.
// Purely combinational, zero cycles.
// Backpressure: none; caller decides when to latch the pick.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  int k;

  // Search ptr+1, ptr+2, ... modulo N and take the first requester.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    k     = 0;
    for (int i = 1; i <= N; i++) begin
      k = int'(ptr_i) + i;
      if (k >= N) k = k - N;
      if (req_i[k] && !vld_o) begin
        vld_o    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/wb_snoop_arbiter.sv
// Write-invalidate arbiter sharing one memory Wishbone port among NUM_CORES masters.
// Read: slave cycle 1 clk after request; write: snoop + ack wait, slave cycle >=3 clks after request.
// Backpressure: losers and snooping owner see no ack; owner holds until its cyc drops. Option: SNOOP_TIMEOUT_EN.
module wb_snoop_arbiter
  import wb_coherent_pkg::*;
#(
  parameter int NUM_CORES     = 2,
  parameter int SNOOP_TIMEOUT = 64
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic [ADR_W*NUM_CORES-1:0] m_adr_i,
  input  logic [DAT_W*NUM_CORES-1:0] m_dat_i,
  input  logic [SEL_W*NUM_CORES-1:0] m_sel_i,
  input  logic [NUM_CORES-1:0]       m_we_i,
  input  logic [NUM_CORES-1:0]       m_cyc_i,
  input  logic [NUM_CORES-1:0]       m_stb_i,
  input  logic [3*NUM_CORES-1:0]     m_cti_i,
  input  logic [2*NUM_CORES-1:0]     m_bte_i,
  output logic [DAT_W*NUM_CORES-1:0] m_dat_o,
  output logic [NUM_CORES-1:0]       m_ack_o,
  output logic [NUM_CORES-1:0]       m_err_o,
  output logic [NUM_CORES-1:0]       m_rty_o,
  output logic [ADR_W-1:0]           s_adr_o,
  output logic [DAT_W-1:0]           s_dat_o,
  output logic [SEL_W-1:0]           s_sel_o,
  output logic                       s_we_o,
  output logic                       s_cyc_o,
  output logic                       s_stb_o,
  output logic [2:0]                 s_cti_o,
  output logic [1:0]                 s_bte_o,
  input  logic [DAT_W-1:0]           s_dat_i,
  input  logic                       s_ack_i,
  input  logic                       s_err_i,
  input  logic                       s_rty_i,
  output logic [ADR_W*NUM_CORES-1:0] snoop_adr_o,
  output logic                       snoop_req_o,
  input  logic [NUM_CORES-1:0]       snoop_ack_i,
  input  logic [NUM_CORES-1:0]       snoop_hit_i,
  output logic [NUM_CORES-1:0]       last_hit_o,
  output logic [NUM_CORES-1:0]       grant_o
);

  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  state_e                 state_q, state_d;
  logic [NUM_CORES-1:0]   grant_q, grant_d;
  logic [NUM_CORES-1:0]   ackmask_q, ackmask_d;
  logic [NUM_CORES-1:0]   last_hit_q, last_hit_d;
  logic [IW-1:0]          ptr_q, ptr_d, owner_q, owner_d;
  logic [ADR_W-1:0]       snoop_adr_q, snoop_adr_d;
  logic                   abort_q, abort_d;
  logic                   to_err;

  logic [NUM_CORES-1:0]   arb_gnt;
  logic [IW-1:0]          arb_idx;
  logic                   arb_vld;

  logic [ADR_W-1:0]       win_adr, own_adr;
  logic [DAT_W-1:0]       own_dat;
  logic [SEL_W-1:0]       own_sel;
  logic [2:0]             own_cti;
  logic [1:0]             own_bte;
  logic                   own_cyc, own_stb, own_we, mask_full, in_grant;

`ifdef SNOOP_TIMEOUT_EN
  localparam int CW = $clog2(SNOOP_TIMEOUT) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  rr_arbiter #(.N(NUM_CORES), .IW(IW)) u_rr (
    .req_i (m_cyc_i & m_stb_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  assign own_cyc   = |(m_cyc_i & grant_q);
  assign own_stb   = |(m_stb_i & grant_q);
  assign own_we    = |(m_we_i & grant_q);
  assign mask_full = &(ackmask_q | snoop_ack_i);
  assign in_grant  = (state_q == GRANT);

  // One-hot muxes: current owner's request fields and the arbitration winner's address.
  always_comb begin
    win_adr = '0;
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    own_cti = '0;
    own_bte = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (arb_gnt[k]) win_adr = win_adr | m_adr_i[k*ADR_W +: ADR_W];
      if (grant_q[k]) begin
        own_adr = own_adr | m_adr_i[k*ADR_W +: ADR_W];
        own_dat = own_dat | m_dat_i[k*DAT_W +: DAT_W];
        own_sel = own_sel | m_sel_i[k*SEL_W +: SEL_W];
        own_cti = own_cti | m_cti_i[k*3 +: 3];
        own_bte = own_bte | m_bte_i[k*2 +: 2];
      end
    end
  end

  // Next-state logic: pick, snoop broadcast, ack collection, grant hold and release.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    ackmask_d   = ackmask_q;
    last_hit_d  = last_hit_q;
    snoop_adr_d = snoop_adr_q;
    abort_d     = abort_q;
    to_err      = 1'b0;
`ifdef SNOOP_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (arb_vld) begin
          grant_d = arb_gnt;
          owner_d = arb_idx;
          if (|(arb_gnt & m_we_i)) begin
            state_d     = SNOOP;
            snoop_adr_d = {win_adr[ADR_W-1:2], 2'b00};
          end else begin
            state_d = GRANT;
          end
        end
      end
      SNOOP: begin
        // The requester never snoops itself, so its bit starts set.
        ackmask_d  = grant_q | snoop_ack_i;
        last_hit_d = snoop_hit_i & ~grant_q;
        if (!own_cyc) abort_d = 1'b1;
`ifdef SNOOP_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        ackmask_d  = ackmask_q | snoop_ack_i;
        last_hit_d = last_hit_q | (snoop_hit_i & ~grant_q);
        if (!own_cyc) abort_d = 1'b1;
        if (mask_full) begin
          // A master that gave up mid-snoop never reaches the slave.
          if (abort_q || !own_cyc) begin
            state_d = IDLE;
            ptr_d   = owner_q;
            grant_d = '0;
          end else begin
            state_d = GRANT;
          end
        end
`ifdef SNOOP_TIMEOUT_EN
        else if (cnt_q == CW'(SNOOP_TIMEOUT - 1)) begin
          to_err  = 1'b1;
          state_d = IDLE;
          ptr_d   = owner_q;
          grant_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      GRANT: begin
        // Bursts hold the grant; release only when the owner drops cyc.
        if (!own_cyc) begin
          state_d = IDLE;
          ptr_d   = owner_q;
          grant_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and bookkeeping registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      ptr_q       <= IW'(NUM_CORES - 1);
      ackmask_q   <= '0;
      last_hit_q  <= '0;
      snoop_adr_q <= '0;
      abort_q     <= 1'b0;
`ifdef SNOOP_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      ackmask_q   <= ackmask_d;
      last_hit_q  <= last_hit_d;
      snoop_adr_q <= snoop_adr_d;
      abort_q     <= abort_d;
`ifdef SNOOP_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign grant_o     = grant_q;
  assign snoop_req_o = (state_q == SNOOP);
  assign snoop_adr_o = {NUM_CORES{snoop_adr_q}};
  assign last_hit_o  = last_hit_q;

  // Slave request and master response steering; everything quiet outside GRANT.
  always_comb begin
    s_adr_o = in_grant ? own_adr : '0;
    s_dat_o = in_grant ? own_dat : '0;
    s_sel_o = in_grant ? own_sel : '0;
    s_cti_o = in_grant ? own_cti : '0;
    s_bte_o = in_grant ? own_bte : '0;
    s_we_o  = in_grant & own_we;
    s_cyc_o = in_grant & own_cyc;
    s_stb_o = in_grant & own_stb;
    m_ack_o = in_grant ? (grant_q & {NUM_CORES{s_ack_i}}) : '0;
    m_rty_o = in_grant ? (grant_q & {NUM_CORES{s_rty_i}}) : '0;
    m_err_o = (in_grant ? (grant_q & {NUM_CORES{s_err_i}}) : '0) |
              (to_err ? grant_q : '0);
    m_dat_o = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (in_grant && grant_q[k]) m_dat_o[k*DAT_W +: DAT_W] = s_dat_i;
    end
  end

endmodule

// File: tb/tb_wb_snoop_arbiter.sv
// Directed bench for wb_snoop_arbiter with two cores.
// Inputs driven 1 time unit after the rising edge, outputs checked after settling.
// Timeout case is built only when SNOOP_TIMEOUT_EN is defined.
module tb_wb_snoop_arbiter;

  localparam int N = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   m_adr, m_dat, m_dat_o, snoop_adr_o;
  logic [7:0]    m_sel;
  logic [1:0]    m_we, m_cyc, m_stb, m_ack_o, m_err_o, m_rty_o;
  logic [5:0]    m_cti;
  logic [3:0]    m_bte;
  logic [31:0]   s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]    s_sel_o;
  logic          s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i, s_rty_i, snoop_req_o;
  logic [2:0]    s_cti_o;
  logic [1:0]    s_bte_o;
  logic [1:0]    snoop_ack, snoop_hit, last_hit_o, grant_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_snoop_arbiter #(.NUM_CORES(N), .SNOOP_TIMEOUT(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_cti_i(m_cti), .m_bte_i(m_bte),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .snoop_adr_o(snoop_adr_o), .snoop_req_o(snoop_req_o),
    .snoop_ack_i(snoop_ack), .snoop_hit_i(snoop_hit),
    .last_hit_o(last_hit_o), .grant_o(grant_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int k, input logic we, input logic [31:0] adr,
                     input logic [31:0] dat, input logic [2:0] cti);
    m_cyc[k] = 1'b1;
    m_stb[k] = 1'b1;
    m_we[k]  = we;
    m_adr[k*32 +: 32] = adr;
    m_dat[k*32 +: 32] = dat;
    m_sel[k*4 +: 4]   = 4'hF;
    m_cti[k*3 +: 3]   = cti;
  endtask

  task automatic drop(input int k);
    m_cyc[k] = 1'b0;
    m_stb[k] = 1'b0;
    m_we[k]  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
    m_cti = '0; m_bte = '0;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    snoop_ack = '0; snoop_hit = '0;
    step(); step();
    check("rst_grant", grant_o, 2'b00);
    check("rst_scyc", s_cyc_o, 1'b0);
    check("rst_sreq", snoop_req_o, 1'b0);
    check("rst_sadr", snoop_adr_o, 64'h0);
    check("rst_hit", last_hit_o, 2'b00);
    check("rst_ack", m_ack_o, 2'b00);
    rst = 1'b0;
    step();

    // Core 0 read at 0x100, slave acks on the third grant cycle.
    req(0, 1'b0, 32'h100, 32'h0, 3'b000);
    #1 check("rd_idle_scyc", s_cyc_o, 1'b0);
    step();
    check("rd_grant", grant_o, 2'b01);
    check("rd_scyc", s_cyc_o, 1'b1);
    check("rd_sadr", s_adr_o, 32'h100);
    check("rd_nosnoop", snoop_req_o, 1'b0);
    step(); step();
    s_ack_i = 1'b1; s_dat_i = 32'hDEADBEEF;
    #1;
    check("rd_ack", m_ack_o, 2'b01);
    check("rd_dat0", m_dat_o[31:0], 32'hDEADBEEF);
    check("rd_dat1", m_dat_o[63:32], 32'h0);
    step();
    s_ack_i = 1'b0; s_dat_i = '0; drop(0);
    step();
    check("rd_release", grant_o, 2'b00);

    // Core 1 write 0x2004, core 0 acks with hit in the third wait cycle.
    req(1, 1'b1, 32'h2004, 32'h12345678, 3'b000);
    step();
    check("wr_sreq", snoop_req_o, 1'b1);
    check("wr_sadr", snoop_adr_o, 64'h00002004_00002004);
    check("wr_grant", grant_o, 2'b10);
    check("wr_snoop_scyc", s_cyc_o, 1'b0);
    step();
    check("wr_w1_sreq", snoop_req_o, 1'b0);
    check("wr_w1_scyc", s_cyc_o, 1'b0);
    step();
    check("wr_w2_scyc", s_cyc_o, 1'b0);
    step();
    snoop_ack = 2'b01; snoop_hit = 2'b01;
    #1 check("wr_w3_scyc", s_cyc_o, 1'b0);
    step();
    snoop_ack = '0; snoop_hit = '0;
    #1;
    check("wr_scyc", s_cyc_o, 1'b1);
    check("wr_swe", s_we_o, 1'b1);
    check("wr_sadr_out", s_adr_o, 32'h2004);
    check("wr_sdat", s_dat_o, 32'h12345678);
    check("wr_lasthit", last_hit_o, 2'b01);
    s_ack_i = 1'b1;
    #1 check("wr_ack", m_ack_o, 2'b10);
    step();
    s_ack_i = 1'b0; drop(1);
    step();
    check("wr_release", grant_o, 2'b00);

    // Both cores request continuously; expect 0,1,0,1 with a dead cycle between.
    req(0, 1'b0, 32'h40, 32'h0, 3'b000);
    req(1, 1'b0, 32'h80, 32'h0, 3'b000);
    for (int t = 0; t < 4; t++) begin
      step();
      check($sformatf("rr_grant%0d", t), grant_o, 2'b01 << (t % 2));
      s_ack_i = 1'b1;
      #1 check($sformatf("rr_ack%0d", t), m_ack_o, 2'b01 << (t % 2));
      step();
      s_ack_i = 1'b0; drop(t % 2);
      step();
      check($sformatf("rr_dead%0d", t), grant_o, 2'b00);
      if (t < 3) req(t % 2, 1'b0, 32'h40, 32'h0, 3'b000);
    end
    drop(0); drop(1);
    step();

    // 8-beat INCR burst on core 0 while core 1 waits.
    req(0, 1'b0, 32'h400, 32'h0, 3'b010);
    req(1, 1'b0, 32'h800, 32'h0, 3'b000);
    step();
    check("bu_grant", grant_o, 2'b01);
    check("bu_cti", s_cti_o, 3'b010);
    for (int b = 0; b < 8; b++) begin
      s_ack_i = 1'b1;
      if (b == 7) m_cti[2:0] = 3'b111;
      #1 check($sformatf("bu_beat%0d", b), {m_ack_o, grant_o}, 4'b0101);
      step();
    end
    s_ack_i = 1'b0; drop(0);
    #1 check("bu_hold", grant_o, 2'b01);
    step();
    check("bu_dead", grant_o, 2'b00);
    step();
    check("bu_core1", grant_o, 2'b10);
    drop(1);
    step();

    // Reset during WAIT, then a normal read from core 0.
    req(0, 1'b1, 32'h300, 32'hA5A5A5A5, 3'b000);
    step();
    check("rs_sreq", snoop_req_o, 1'b1);
    step();
    rst = 1'b1; drop(0);
    step();
    check("rs_grant", grant_o, 2'b00);
    check("rs_sreq0", snoop_req_o, 1'b0);
    check("rs_scyc", s_cyc_o, 1'b0);
    rst = 1'b0;
    step();
    req(0, 1'b0, 32'h500, 32'h0, 3'b000);
    step();
    check("rs_after_grant", grant_o, 2'b01);
    check("rs_after_sadr", s_adr_o, 32'h500);
    drop(0);
    step();

    // Owner abandons its write during the snoop: snoop finishes, slave never sees it.
    req(1, 1'b1, 32'h600, 32'h0, 3'b000);
    step();
    drop(1);
    step();
    snoop_ack = 2'b01;
    #1 check("ab_wait_scyc", s_cyc_o, 1'b0);
    step();
    snoop_ack = '0;
    #1;
    check("ab_grant", grant_o, 2'b00);
    check("ab_scyc", s_cyc_o, 1'b0);
    step();

`ifdef SNOOP_TIMEOUT_EN
    // Core 1 write, core 0 never acks: error pulse in the 8th wait cycle.
    req(1, 1'b1, 32'h700, 32'h0, 3'b000);
    step();
    for (int w = 1; w <= 8; w++) begin
      step();
      check($sformatf("to_err%0d", w), m_err_o, (w == 8) ? 2'b10 : 2'b00);
      check($sformatf("to_scyc%0d", w), s_cyc_o, 1'b0);
    end
    drop(1);
    step();
    check("to_release", grant_o, 2'b00);
    check("to_err_clear", m_err_o, 2'b00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_snoop_arbiter.md
Name: wb_snoop_arbiter

Overview:
- Shares the single main-memory Wishbone slave port between the NUM_CORES mor1kx data-bus masters.
- Write-invalidate coherence: before a granted write reaches memory, broadcasts a snoop (invalidate) on the snoop bus and waits for every other core's acknowledge.
- Reads pass straight through; dcaches are write-through, so memory is always current.
- Sits between the cores' dwbm ports and the memory branch of the interconnect.

Parameters:
- NUM_CORES, 2, number of data-bus masters and snoop agents (1..8).
- SNOOP_TIMEOUT, 64, snoop-wait watchdog limit in cycles; used only with the optional feature.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  reset: synchronous to wb_clk_i, active-high.
- m_adr_i  in  32*NUM_CORES  packed master addresses; slice k = bits [32k+31:32k].
- m_dat_i  in  32*NUM_CORES  packed master write data.
- m_sel_i  in  4*NUM_CORES  byte selects.
- m_we_i, m_cyc_i, m_stb_i  in  NUM_CORES  per-master control.
- m_cti_i  in  3*NUM_CORES  cycle type.
- m_bte_i  in  2*NUM_CORES  burst type.
- m_dat_o  out  32*NUM_CORES  read data.
- m_ack_o, m_err_o, m_rty_o  out  NUM_CORES  per-master responses.
- s_adr_o  out  32, s_dat_o  out  32, s_sel_o  out  4  slave request fields.
- s_we_o, s_cyc_o, s_stb_o  out  1  slave control.
- s_cti_o  out  3, s_bte_o  out  2  slave burst fields.
- s_dat_i  in  32, s_ack_i, s_err_i, s_rty_i  in  1  slave response.
- snoop_adr_o  out  32*NUM_CORES  snoop address, same value in every slice.
- snoop_req_o  out  1  one-cycle snoop strobe.
- snoop_ack_i  in  NUM_CORES  per-core snoop done.
- snoop_hit_i  in  NUM_CORES  per-core hit (informational only).
- last_hit_o  out  NUM_CORES  hit vector captured from the last snoop.
- grant_o  out  NUM_CORES  one-hot current owner; all zero when idle.

Behaviour:
- FSM states: IDLE, SNOOP, WAIT, GRANT.
- Reset values: state=IDLE; ptr=NUM_CORES-1 so core 0 wins first; grant_o=0; snoop_req_o=0; snoop_adr_o=0; last_hit_o=0; all s_* outputs 0; all m_ack/err/rty_o 0.
- IDLE: request vector req[k]=m_cyc_i[k]&m_stb_i[k].
  - Round-robin pick: first set req searching ptr+1, ptr+2, … modulo NUM_CORES.
  - Registered: owner latched and grant_o set at the clock edge.
  - Next state is SNOOP if the owner's m_we_i=1, else GRANT.
- SNOOP (1 cycle):
  - snoop_req_o=1; snoop_adr_o slices = owner address with bits[1:0] forced to 0.
  - ackmask cleared to the owner's own bit set, since the requester never snoops itself.
  - Go to WAIT.
- WAIT:
  - ackmask |= snoop_ack_i each cycle; acks are accepted from the SNOOP cycle onward.
  - last_hit_o |= snoop_hit_i & ~owner-bit.
  - When (ackmask | snoop_ack_i) is all ones, go to GRANT. Minimum write latency to s_cyc_o is 3 cycles after the request.
  - NUM_CORES=1: mask is already full, so WAIT lasts 1 cycle.
- GRANT:
  - s_* = owner's inputs combinationally.
  - m_dat_o[owner]=s_dat_i; m_ack/err/rty_o[owner] = s_ack/err/rty_i. All other masters' responses are 0; m_dat_o for other masters is 0.
  - Bursts (cti 010) stay granted until the owner drops m_cyc_i.
  - On m_cyc_i[owner]=0: go to IDLE, ptr=owner, grant_o=0. One dead cycle between grants guarantees fairness.
- Owner drops cyc during SNOOP/WAIT: the snoop still completes (invalidate is harmless), then IDLE; the slave never sees the cycle.
- Simultaneous requests: strict round-robin; a master re-requesting right after its grant loses to any other pending master.
- Reset asserted mid-operation: return to IDLE next edge, all outputs at reset values; the slave sees s_cyc_o fall immediately.
- Non-GRANT states: s_cyc_o=s_stb_o=s_we_o=0, other s_* fields 0.

Optional Feature:
- Macro SNOOP_TIMEOUT_EN.
- Defined:
  - A counter (clog2(SNOOP_TIMEOUT)+1 bits) clears in SNOOP and increments in WAIT.
  - On reaching SNOOP_TIMEOUT with an incomplete mask, m_err_o[owner]=1 for one cycle, then state=IDLE and ptr=owner; the write is never issued.
- Not defined: no counter; WAIT waits indefinitely.

Decomposition:
- Shared package wb_coherent_pkg holds:
  - state encoding enum (IDLE=0, SNOOP=1, WAIT=2, GRANT=3);
  - CTI constants (CLASSIC=000, INCR=010, EOB=111);
  - width localparams for ADR, DAT, SEL.
- One natural sub-module, rr_arbiter: request vector plus last pointer in, one-hot grant plus index out, purely combinational pick. The FSM, snoop sequencing and muxing stay in the top module.

Test Plan:
- Core 0 read at 0x100, slave acks after 2 cycles → s_cyc_o rises 1 cycle after the request, no snoop_req_o, m_ack_o=01, s_dat_i 0xDEADBEEF appears on m_dat_o slice 0.
- Core 1 write 0x2004, data 0x12345678, core 0 acks snoop 3 cycles late with hit=1 → snoop_adr_o=0x2004 in both slices, s_cyc_o held low until the ack, then write issued, last_hit_o=01.
- Cores 0 and 1 request simultaneously and continuously for 4 transactions → grant order 0,1,0,1 with one idle cycle between grants.
- Core 0 issues an 8-beat INCR burst read while core 1 requests → core 1 grant_o stays 0 until core 0 drops cyc after beat 8.
- Reset asserted during WAIT → next cycle state IDLE, snoop_req_o=0, grant_o=0, s_cyc_o=0; the next request from core 0 is served normally.
- With SNOOP_TIMEOUT_EN and SNOOP_TIMEOUT=8, core 1 writes and core 0 never acks → m_err_o[1] pulses at WAIT cycle 8, s_cyc_o never asserts.
